instr_decode: RTL and testbench

Instruction-decode stage of the single-cycle/sequential 32-bit MIPS-style datapath. It takes the fetched instruction word and splits it into opcode, source-register pair and destination-register index. It forwards the raw word unchanged for immediate/funct extraction downstream. All outputs are registered, one clock after the instruction is presented, and feed the register file and control unit.

---
 rtl/instr_decode_if.sv | 25 ++
 rtl/instr_decode.sv | 83 ++++++++
 tb/tb_instr_decode.sv | 129 ++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// Decode-stage bus: the fetched instruction in, the registered decoded fields out.
// The master drives the instruction; the slave (the decoder) drives the fields.
interface instr_decode_if;
  logic [31:0] instr_in;
  logic [5:0]  opcode;
  logic [9:0]  rs_rt;
  logic [4:0]  rwd;
  logic [31:0] instr_out;

  modport master (
    output instr_in,
    input  opcode,
    input  rs_rt,
    input  rwd,
    input  instr_out
  );

  modport slave (
    input  instr_in,
    output opcode,
    output rs_rt,
    output rwd,
    output instr_out
  );
endinterface

// File: rtl/instr_decode.sv
// MIPS-style instruction-decode stage: slices opcode and {rs,rt}, chooses the
// destination register index and registers everything one cycle after instr_in.
module instr_decode (
  input  logic              clk,
  input  logic              rst,
  instr_decode_if.slave     bus
);

  typedef enum logic [1:0] {
    DST_NONE,
    DST_RD,
    DST_RT,
    DST_RA
  } dst_sel_e;

  localparam logic [5:0] FUNCT_JR = 6'b001000;
  localparam logic [4:0] REG_RA   = 5'd31;

  logic [5:0]  op_w;
  logic [4:0]  rt_w;
  logic [4:0]  rd_w;
  logic [5:0]  funct_w;
  dst_sel_e    dst_sel;

  logic [5:0]  opcode_d,    opcode_q;
  logic [9:0]  rs_rt_d,     rs_rt_q;
  logic [4:0]  rwd_d,       rwd_q;
  logic [31:0] instr_d,     instr_q;

  assign op_w    = bus.instr_in[31:26];
  assign rt_w    = bus.instr_in[20:16];
  assign rd_w    = bus.instr_in[15:11];
  assign funct_w = bus.instr_in[5:0];

  // Destination class per opcode; anything without a register write maps to $0.
  always_comb begin
    dst_sel = DST_NONE;
    casez (op_w)
      6'b000000: dst_sel = (funct_w == FUNCT_JR) ? DST_NONE : DST_RD;
      6'b000011: dst_sel = DST_RA;
      6'b001???: dst_sel = DST_RT;
      6'b100000,
      6'b100001,
      6'b100011,
      6'b100100,
      6'b100101: dst_sel = DST_RT;
      default:   dst_sel = DST_NONE;
    endcase
  end

  always_comb begin
    opcode_d = op_w;
    rs_rt_d  = bus.instr_in[25:16];
    instr_d  = bus.instr_in;
    rwd_d    = '0;
    unique case (dst_sel)
      DST_RD:   rwd_d = rd_w;
      DST_RT:   rwd_d = rt_w;
      DST_RA:   rwd_d = REG_RA;
      default:  rwd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      rs_rt_q  <= '0;
      rwd_q    <= '0;
      instr_q  <= '0;
    end else begin
      opcode_q <= opcode_d;
      rs_rt_q  <= rs_rt_d;
      rwd_q    <= rwd_d;
      instr_q  <= instr_d;
    end
  end

  assign bus.opcode    = opcode_q;
  assign bus.rs_rt     = rs_rt_q;
  assign bus.rwd       = rwd_q;
  assign bus.instr_out = instr_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: literal per-vector expectations plus a
// per-cycle comparison against an opcode-rule model of the decode stage.
module tb_instr_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_decode_if bus ();

  instr_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination register from the decode rules, written from the opcode table.
  function automatic logic [4:0] model_rwd(input logic [31:0] w);
    int unsigned op, funct;
    op    = int'(w >> 26);
    funct = int'(w & 32'h3F);
    if (op == 0)                 return (funct == 8) ? 5'd0 : w[15:11];
    if (op == 3)                 return 5'd31;
    if (op >= 8 && op <= 15)     return w[20:16];
    if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) return w[20:16];
    return 5'd0;
  endfunction

  logic [31:0] m_instr;
  logic [4:0]  m_rwd;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_instr <= 32'h0;
      m_rwd   <= 5'd0;
      m_valid <= 1'b1;
    end else begin
      m_instr <= bus.instr_in;
      m_rwd   <= model_rwd(bus.instr_in);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_opcode",    32'(bus.opcode),  32'(m_instr >> 26));
      chk("model_rs_rt",     32'(bus.rs_rt),   (m_instr >> 16) & 32'h3FF);
      chk("model_rwd",       32'(bus.rwd),     32'(m_rwd));
      chk("model_instr_out", bus.instr_out,    m_instr);
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic        rst;
    logic [5:0]  op;
    logic [9:0]  rs_rt;
    logic [4:0]  rwd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] i, input logic r, input logic [5:0] o,
                         input logic [9:0] s, input logic [4:0] d);
    vec_t v;
    v.instr = i; v.rst = r; v.op = o; v.rs_rt = s; v.rwd = d;
    vecs.push_back(v);
  endtask

  initial begin
    bus.instr_in = 32'hFFFF_FFFF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_opcode",    32'(bus.opcode), 32'h0);
    chk("reset_rs_rt",     32'(bus.rs_rt),  32'h0);
    chk("reset_rwd",       32'(bus.rwd),    32'h0);
    chk("reset_instr_out", bus.instr_out,   32'h0);

    add_vec(32'h0000_0000, 1'b0, 6'h00, 10'h000, 5'd0);
    add_vec(32'h0022_1820, 1'b0, 6'h00, 10'h022, 5'd3);
    add_vec(32'h03E0_0008, 1'b0, 6'h00, 10'h3E0, 5'd0);
    add_vec(32'h2085_0007, 1'b0, 6'h08, 10'h085, 5'd5);
    add_vec(32'h8CE6_0004, 1'b0, 6'h23, 10'h0E6, 5'd6);
    add_vec(32'hACE6_0004, 1'b0, 6'h2B, 10'h0E6, 5'd0);
    add_vec(32'h1022_0003, 1'b0, 6'h04, 10'h022, 5'd0);
    add_vec(32'h0C00_0010, 1'b0, 6'h03, 10'h000, 5'd31);
    add_vec(32'h3C1F_1234, 1'b0, 6'h0F, 10'h01F, 5'd31);
    add_vec(32'h0022_1820, 1'b1, 6'h00, 10'h000, 5'd0);
    add_vec(32'h94A5_0000, 1'b0, 6'h25, 10'h0A5, 5'd5);
    add_vec(32'h8843_0000, 1'b0, 6'h22, 10'h043, 5'd0);
    add_vec(32'h4000_0000, 1'b0, 6'h10, 10'h000, 5'd0);
    add_vec(32'h0060_F809, 1'b0, 6'h00, 10'h060, 5'd31);
    add_vec(32'h2000_FFFF, 1'b0, 6'h08, 10'h000, 5'd0);
    add_vec(32'h0800_0000, 1'b0, 6'h02, 10'h000, 5'd0);

    foreach (vecs[k]) begin
      @(negedge clk);
      #1;
      bus.instr_in = vecs[k].instr;
      rst          = vecs[k].rst;
      @(posedge clk);
      #2;
      chk($sformatf("v%0d_opcode", k),    32'(bus.opcode), 32'(vecs[k].op));
      chk($sformatf("v%0d_rs_rt", k),     32'(bus.rs_rt),  32'(vecs[k].rs_rt));
      chk($sformatf("v%0d_rwd", k),       32'(bus.rwd),    32'(vecs[k].rwd));
      chk($sformatf("v%0d_instr_out", k), bus.instr_out,
          vecs[k].rst ? 32'h0 : vecs[k].instr);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
